// File: rtl/uart_tx_ctrl.sv
// UART transmit serializer fed by the TX byte FIFO. Each popped byte leaves as
// start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop bits.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       read_enable,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] state_dbg_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;

  // FIFO handshake: read_enable is a one-cycle pop, asserted only in IDLE while
  // the FIFO is non-empty; the popped byte is presented on fifo_dout during LOAD.
  assign read_enable = (state_q == IDLE) && !fifo_empty && !rst;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_end = (baud_q == BIT_LAST);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = fifo_dout;
        par_d   = (^fifo_dout) ^ PAR_INV;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = HAS_PAR ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        // All stop bits are timed as one stretch of STOP_BITS * CLKS_PER_BIT cycles.
        if (baud_q == STOP_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line level and
  // flags line up with the state they describe.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == STOP_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances cover no-parity, even, odd and two-stop
// framing; a FIFO model feeds them and a line monitor scores every frame.
module tb_uart_tx_ctrl;

  localparam int C = 4;
  localparam int N = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]      empty_v = '1;
  logic [N-1:0][7:0] dout_v  = '0;
  logic [N-1:0]      re_v, tx_v, busy_v, done_v;
  logic [3*N-1:0]    st_v;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_ctrl #(
      .CLKS_PER_BIT(C),
      .PARITY_EN((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD((g == 2) ? 1 : 0),
      .STOP_BITS((g == 3) ? 2 : 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .fifo_empty(empty_v[g]),
      .fifo_dout(dout_v[g]),
      .read_enable(re_v[g]),
      .tx(tx_v[g]),
      .tx_busy(busy_v[g]),
      .tx_done(done_v[g]),
      .state_dbg_o(st_v[3*g +: 3])
    );
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(string name, int lane, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s lane=%0d actual=%0h expected=%0h", name, lane, act, exp);
    end
  endtask

  // Hand-computed frame lengths: (10 + parity + extra stop) * 4.
  function automatic int frame_len(int l);
    return (l == 0) ? 40 : 44;
  endfunction

  function automatic logic has_par(int l);
    return (l == 1 || l == 2);
  endfunction

  // FIFO model: registered read data, empty flag updated on the clock edge
  logic [7:0]   fmem [N][16];
  int           wr_ptr [N];
  int           rd_ptr [N];
  logic [N-1:0] re_s = '0;

  always @(negedge clk) re_s <= re_v;

  always @(posedge clk) begin
    for (int l = 0; l < N; l++) begin
      if (re_s[l]) begin
        chk("fifo_pop_has_data", l, (rd_ptr[l] != wr_ptr[l]), 1);
        dout_v[l] <= fmem[l][rd_ptr[l] % 16];
        rd_ptr[l] = rd_ptr[l] + 1;
      end
      empty_v[l] <= (rd_ptr[l] == wr_ptr[l]);
    end
  end

  // scoreboard: {lane[1:0], parity, data[7:0]}
  logic [10:0] exp_q [$];
  int          pop_t [$];

  task automatic push(int l, logic [7:0] d, logic p);
    fmem[l][wr_ptr[l] % 16] = d;
    wr_ptr[l] = wr_ptr[l] + 1;
    exp_q.push_back({2'(l), p, d});
  endtask

  // monitor
  int          fcyc [N] = '{default: -1};
  logic [10:0] cur  [N];
  logic [7:0]  rxb  [N];
  int          cyc_cnt = 0;

  task automatic frame_check(int l);
    int   c;
    int   k;
    int   f;
    logic etx;
    c = fcyc[l];
    f = frame_len(l);
    if (c == 1) begin
      etx = 1'b1;
    end else begin
      k = (c - 2) / C;
      if (k == 0)                     etx = 1'b0;
      else if (k <= 8)                etx = cur[l][k-1];
      else if (k == 9 && has_par(l))  etx = cur[l][8];
      else                            etx = 1'b1;
    end
    chk("tx", l, tx_v[l], etx);
    chk("busy", l, busy_v[l], 1);
    chk("re_in_frame", l, re_v[l], 0);
    chk("done", l, done_v[l], (c == f + 1));
    if (c >= 2 && ((c - 2) % C) == C / 2) begin
      k = (c - 2) / C;
      if (k >= 1 && k <= 8) rxb[l][k-1] = tx_v[l];
      if (k == 9 && has_par(l)) chk("parity_bit", l, tx_v[l], cur[l][8]);
    end
    if (c == f + 1) begin
      chk("rx_byte", l, rxb[l], cur[l][7:0]);
      fcyc[l] = -1;
    end
  endtask

  always @(negedge clk) begin
    cyc_cnt++;
    for (int l = 0; l < N; l++) begin
      if (rst) begin
        fcyc[l] = -1;
      end else if (fcyc[l] < 0) begin
        chk("idle_tx", l, tx_v[l], 1);
        chk("idle_busy", l, busy_v[l], 0);
        chk("idle_done", l, done_v[l], 0);
        if (re_v[l]) begin
          chk("re_while_empty", l, empty_v[l], 0);
          chk("pending_expect", l, (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur[l] = exp_q.pop_front();
            chk("pop_lane", l, cur[l][10:9], l);
            fcyc[l] = 0;
            rxb[l]  = '0;
            pop_t.push_back(cyc_cnt);
          end
        end
      end else begin
        fcyc[l] = fcyc[l] + 1;
        frame_check(l);
      end
    end
  end

  // driver helpers
  function automatic logic any_active();
    logic a = 1'b0;
    for (int l = 0; l < N; l++) if (fcyc[l] >= 0) a = 1'b1;
    return a;
  endfunction

  task automatic wait_quiet(int budget);
    int n = 0;
    repeat (3) begin @(negedge clk); #1; end
    while ((exp_q.size() != 0 || any_active()) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_errs++;
      $display("FAIL timeout pending=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;

    // reset state
    repeat (2) begin @(negedge clk); #1; end
    for (int l = 0; l < N; l++) begin
      chk("rst_tx", l, tx_v[l], 1);
      chk("rst_re", l, re_v[l], 0);
      chk("rst_busy", l, busy_v[l], 0);
      chk("rst_done", l, done_v[l], 0);
      chk("rst_state", l, st_v[3*l +: 3], 0);
    end
    rst = 1'b0;
    repeat (5) begin @(negedge clk); #1; end

    // asynchronous reset in the middle of data bit 1 of 0x3C (a 0 bit)
    push(0, 8'h3C, 1'b0);
    n = 0;
    while (fcyc[0] != 11 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_data_bit", 0, fcyc[0], 11);
    chk("pre_reset_tx", 0, tx_v[0], 0);
    rst = 1'b1;
    #1;
    chk("midframe_rst_tx", 0, tx_v[0], 1);
    chk("midframe_rst_busy", 0, busy_v[0], 0);
    chk("midframe_rst_state", 0, st_v[2:0], 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    n0 = pop_t.size();
    repeat (20) begin @(negedge clk); #1; end
    chk("no_reread_after_rst", 0, pop_t.size(), n0);

    // single byte, no parity
    push(0, 8'h55, 1'b0);
    wait_quiet(300);

    // even parity
    push(1, 8'h07, 1'b1);
    push(1, 8'h55, 1'b0);
    wait_quiet(300);

    // odd parity
    push(2, 8'h07, 1'b0);
    push(2, 8'h55, 1'b1);
    wait_quiet(300);

    // two stop bits
    push(3, 8'hA3, 1'b0);
    wait_quiet(300);

    // back-to-back frames from a preloaded FIFO
    pop_t.delete();
    push(0, 8'h01, 1'b0);
    push(0, 8'h80, 1'b0);
    push(0, 8'hFF, 1'b0);
    wait_quiet(400);
    chk("b2b_pop_count", 0, pop_t.size(), 3);
    if (pop_t.size() == 3) begin
      chk("b2b_gap1", 0, pop_t[1] - pop_t[0], 42);
      chk("b2b_gap2", 0, pop_t[2] - pop_t[1], 42);
    end

    // long idle with an empty FIFO
    n0 = pop_t.size();
    repeat (200) begin @(negedge clk); #1; end
    chk("idle_no_pop", 0, pop_t.size(), n0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
